// File: rtl/phy_tx_pkg.sv
// Shared definitions for the phy_tx link-startup sequencer and lane scheduler.
package phy_tx_pkg;

    // Sequencer states; the encoding is fixed so it can be probed in the lab.
    typedef enum logic [1:0] {
        DISABLED  = 2'd0,
        TRAIN_COM = 2'd1,
        TRAIN_SKP = 2'd2,
        ACTIVE    = 2'd3
    } tx_state_t;

    // Default control symbols (8b/10b K28.5 comma and K28.3 skip).
    localparam logic [7:0] COM_SYM_DEF = 8'hBC;
    localparam logic [7:0] SKP_SYM_DEF = 8'h7C;

    // Number of lanes sharing the serial byte stream.
    localparam int NUM_LANES = 4;

    // Lane reached by stepping 'step' positions past 'ptr' (mod 4).
    function automatic logic [1:0] lane_after(input logic [1:0] ptr, input logic [2:0] step);
        return ptr + step[1:0];
    endfunction

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin arbiter: searches from ptr+1 upwards
// and grants the first valid lane, unless en is low.
module rr_arb4
    import phy_tx_pkg::*;
(
    input  logic       en,
    input  logic [3:0] valid,
    input  logic [1:0] ptr,
    output logic [3:0] grant,
    output logic [1:0] idx,
    output logic       any
);

    logic [1:0] lane;

    // Walk the four lanes in priority order and stop at the first valid one.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        lane  = '0;
        for (int s = 1; s <= NUM_LANES; s++) begin
            lane = lane_after(ptr, 3'(s));
            if (en && !any && valid[lane]) begin
                any         = 1'b1;
                idx         = lane;
                grant[lane] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/phy_tx_sched.sv
// Link-startup sequencer and 4-lane round-robin byte scheduler feeding the
// phy_tx serializer. Emits the comma/skip training pattern after enable,
// then multiplexes lane bytes with periodic skip insertion and idle commas.
module phy_tx_sched
    import phy_tx_pkg::*;
#(
    parameter int         COM_REPS     = 4,
    parameter int         SKP_REPS     = 3,
    parameter int         TRAIN_ROUNDS = 2,
    parameter int         SKP_INTERVAL = 16,
    parameter logic [7:0] COM_SYM      = COM_SYM_DEF,
    parameter logic [7:0] SKP_SYM      = SKP_SYM_DEF
) (
    input  logic       clk_4f,
    input  logic       reset_L,
    input  logic       tx_en,
    input  logic       valid0,
    input  logic       valid1,
    input  logic       valid2,
    input  logic       valid3,
    input  logic [7:0] data_in0,
    input  logic [7:0] data_in1,
    input  logic [7:0] data_in2,
    input  logic [7:0] data_in3,
    output logic       ready0,
    output logic       ready1,
    output logic       ready2,
    output logic       ready3,
    output logic [7:0] tx_data,
    output logic       tx_k,
    output logic [1:0] tx_lane,
    output logic       link_up
);

    localparam logic [3:0] COM_LAST   = 4'(COM_REPS - 1);
    localparam logic [3:0] SKP_LAST   = 4'(SKP_REPS - 1);
    localparam logic [3:0] ROUND_LAST = 4'(TRAIN_ROUNDS - 1);
    localparam logic [7:0] SKPI_LAST  = 8'(SKP_INTERVAL - 1);

    tx_state_t  state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [3:0] round, round_nxt;
    logic [7:0] skp_cnt, skp_cnt_nxt;
    logic [1:0] ptr, ptr_nxt;

    logic [7:0] data_nxt;
    logic       k_nxt;
    logic [1:0] lane_nxt;
    logic       link_nxt;

    logic [3:0] valid_vec;
    logic [7:0] lane_data [NUM_LANES];
    logic       skip_due;
    logic       arb_en;
    logic [3:0] arb_grant;
    logic [1:0] arb_idx;
    logic       arb_any;

    assign valid_vec    = {valid3, valid2, valid1, valid0};
    assign lane_data[0] = data_in0;
    assign lane_data[1] = data_in1;
    assign lane_data[2] = data_in2;
    assign lane_data[3] = data_in3;

    // Lanes may only be granted in an enabled ACTIVE cycle with no skip due.
    assign skip_due = (skp_cnt == SKPI_LAST);
    assign arb_en   = tx_en && (state == ACTIVE) && !skip_due;

    rr_arb4 u_arb (
        .en    (arb_en),
        .valid (valid_vec),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign ready0 = arb_grant[0];
    assign ready1 = arb_grant[1];
    assign ready2 = arb_grant[2];
    assign ready3 = arb_grant[3];

    // Next-state, counter and output-symbol decision for this cycle.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        round_nxt   = round;
        skp_cnt_nxt = skp_cnt;
        ptr_nxt     = ptr;
        data_nxt    = COM_SYM;
        k_nxt       = 1'b1;
        lane_nxt    = 2'd0;
        link_nxt    = 1'b0;

        if (!tx_en) begin
            state_nxt   = DISABLED;
            cnt_nxt     = '0;
            round_nxt   = '0;
            skp_cnt_nxt = '0;
        end else begin
            case (state)
                DISABLED: begin
                    state_nxt = TRAIN_COM;
                    cnt_nxt   = '0;
                    round_nxt = '0;
                end
                TRAIN_COM: begin
                    if (cnt == COM_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = TRAIN_SKP;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
                TRAIN_SKP: begin
                    data_nxt = SKP_SYM;
                    if (cnt == SKP_LAST) begin
                        cnt_nxt = '0;
                        if (round == ROUND_LAST) begin
                            round_nxt   = '0;
                            skp_cnt_nxt = '0;
                            state_nxt   = ACTIVE;
                        end else begin
                            round_nxt = round + 4'd1;
                            state_nxt = TRAIN_COM;
                        end
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
                ACTIVE: begin
                    link_nxt = 1'b1;
                    if (skip_due) begin
                        data_nxt    = SKP_SYM;
                        skp_cnt_nxt = '0;
                    end else begin
                        skp_cnt_nxt = skp_cnt + 8'd1;
                        if (arb_any) begin
                            data_nxt = lane_data[arb_idx];
                            k_nxt    = 1'b0;
                            lane_nxt = arb_idx;
                            ptr_nxt  = arb_idx;
                        end
                    end
                end
                default: state_nxt = DISABLED;
            endcase
        end
    end

    // Sequencer state, training counters and round-robin pointer.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state   <= DISABLED;
            cnt     <= '0;
            round   <= '0;
            skp_cnt <= '0;
            ptr     <= 2'd3;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            round   <= round_nxt;
            skp_cnt <= skp_cnt_nxt;
            ptr     <= ptr_nxt;
        end
    end

    // Registered byte stream towards the serializer.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            tx_data <= 8'h00;
            tx_k    <= 1'b0;
            tx_lane <= 2'd0;
            link_up <= 1'b0;
        end else begin
            tx_data <= data_nxt;
            tx_k    <= k_nxt;
            tx_lane <= lane_nxt;
            link_up <= link_nxt;
        end
    end

endmodule

// File: doc/phy_tx_sched.md
Name: phy_tx_sched

Overview:
Link-startup sequencer and 4-lane round-robin scheduler placed in front of the phy_tx byte serializer, in the clk_4f domain. After enable it emits the training pattern: COM_REPS comma (BC) symbols, then SKP_REPS skip (7C) symbols, repeated TRAIN_ROUNDS times. It then arbitrates lane bytes fairly onto one serial byte stream, periodically inserting skip symbols and filling unused slots with idle commas. The serializer consumes exactly one tx_data byte per clk_4f cycle.

Parameters:
COM_REPS, 4, comma symbols per training round (1..15)
SKP_REPS, 3, skip symbols per training round (1..15)
TRAIN_ROUNDS, 2, training rounds before link_up (1..15)
SKP_INTERVAL, 16, ACTIVE cycles between forced skip insertions (2..255)
COM_SYM, 8'hBC, comma/idle code
SKP_SYM, 8'h7C, skip code

Ports:
clk_4f  in  1  byte clock, all logic on rising edge
reset_L  in  1  asynchronous active-low reset
tx_en  in  1  link enable
valid0..valid3  in  1 each  lane i has a byte pending
data_in0..data_in3  in  8 each  lane i byte
ready0..ready3  out  1 each  lane i byte taken this edge (combinational grant)
tx_data  out  8  byte to serializer (registered)
tx_k  out  1  1 = tx_data is a control symbol (registered)
tx_lane  out  2  source lane of tx_data when tx_k=0 (registered)
link_up  out  1  high in ACTIVE (registered)

Behaviour:
- One clock (clk_4f); reset is asynchronous and active-low (reset_L). Reset asserted: state DISABLED, tx_data=8'h00, tx_k=0, tx_lane=0, link_up=0, ready0..3=0, counters=0, RR pointer=3 (so lane 0 has first priority).
- Registered outputs update one edge after the decision; ready_i is combinational and asserted in the decision cycle, and data_in_i is captured on that same edge.
- States:
  - DISABLED: tx_data=COM_SYM, tx_k=1 each cycle after the first post-reset edge. tx_en=1 -> TRAIN_COM with round=0 and cnt=0.
  - TRAIN_COM: emit COM_SYM with k=1. After COM_REPS emissions -> TRAIN_SKP.
  - TRAIN_SKP: emit SKP_SYM with k=1. After SKP_REPS emissions: round+1; if round==TRAIN_ROUNDS -> ACTIVE, else -> TRAIN_COM.
  - ACTIVE: link_up=1. Per cycle, in priority order:
    - If skip counter == SKP_INTERVAL-1: emit SKP_SYM, k=1, no ready, counter cleared.
    - Else, if any valid: grant the first valid lane searching from pointer+1 mod 4. Assert ready_i, emit data_in_i with k=0 and tx_lane=i, pointer set to i.
    - Else emit COM_SYM with k=1 (idle).
    - The skip counter increments every ACTIVE cycle.
- Total training length is TRAIN_ROUNDS*(COM_REPS+SKP_REPS) symbols (14 at defaults). link_up rises with the first ACTIVE output.
- No ready is asserted outside ACTIVE, regardless of valid.
- tx_en=0 in any state: the next state is DISABLED, no grant that cycle, and training counters are cleared. Re-enabling always restarts full training.
- A skip collision takes precedence over pending lanes; the pointer is unchanged, so lanes lose no fairness.
- A single requester is granted back-to-back every non-skip cycle.
- Counters wrap: the pointer is mod 4, and the skip counter resets to 0 on entry to ACTIVE.
- Reset asserted mid-operation returns all outputs to reset values immediately (asynchronously).

Decomposition:
- Package phy_tx_pkg: state encoding constants (DISABLED=2'd0, TRAIN_COM=2'd1, TRAIN_SKP=2'd2, ACTIVE=2'd3), COM_SYM/SKP_SYM defaults, lane count (4).
- Sub-module rr_arb4: a combinational 4-way round-robin grant from valid[3:0] and pointer[1:0]. It outputs one-hot grant plus the encoded index, with an enable input to suppress grants.

Test Plan:
- Reset then tx_en=1 -> tx_data sequence BC,BC,BC,BC,7C,7C,7C twice (k=1), link_up=1 on 15th output, ready all 0 throughout.
- ACTIVE, valid0..3=1 with data FF/EE/DD/CC held -> tx_data FF,EE,DD,CC,FF..., tx_lane 0,1,2,3,0, ready one-hot rotating.
- ACTIVE, valid2=1 only with data 77 -> 77 every cycle except one 7C every 16th ACTIVE cycle; ready2 low on that cycle.
- ACTIVE, all valid=0 -> BC k=1 idles, with 7C every 16 cycles.
- tx_en dropped in ACTIVE with lanes valid -> ready all 0 that cycle, link_up=0 next edge, BC idles. Re-enable -> full 14-symbol training again.
- reset_L asserted mid-training (between clock edges) -> tx_data=00, tx_k=0, link_up=0 immediately. Release with tx_en=1 -> training restarts from round 0.
